// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle control unit and the datapath/memory side.
// The master modport belongs to the control unit; the slave modport to the datapath.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             jump;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    // Memory handshake: mem_req stays high every cycle until the cycle in which
    // mem_ready is high; that cycle completes the transfer.
    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               trap, state, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               trap, state, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeout, sticky trap and a retired-instruction counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter int WAIT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_ILL6   = 3'd6,
        S_ILL7   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_q, trap_d;

    logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
    logic       branch_c, jump_c, reg_write_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, wb_sel_c;
    logic       legal_op, in_mem_phase, timeout_hit, retire;

    assign legal_op = (bus.opcode == OP_R)   || (bus.opcode == OP_I)   ||
                      (bus.opcode == OP_LW)  || (bus.opcode == OP_SW)  ||
                      (bus.opcode == OP_BEQ) || (bus.opcode == OP_JAL) ||
                      (bus.opcode == OP_LUI);

    assign in_mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);

    // The final allowed wait cycle traps only if the handshake does not complete in it.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                         (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        branch_c    = 1'b0;
        jump_c      = 1'b0;
        reg_write_c = 1'b0;
        src_a_c     = 2'b00;
        src_b_c     = 2'b00;
        alu_op_c    = 2'b00;
        wb_sel_c    = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_a_c   = 2'b01;
                src_b_c   = 2'b01;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                src_a_c = 2'b10;
                src_b_c = 2'b10;
                state_d = legal_op ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        src_b_c  = 2'b10;
                        alu_op_c = 2'b11;
                        state_d  = S_WB;
                    end
                    OP_LUI: begin
                        src_b_c = 2'b10;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        src_b_c = 2'b10;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c = 2'b01;
                        branch_c = 1'b1;
                        jump_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_write_c = 1'b1;
                        wb_sel_c    = 2'b10;
                        pc_write_c  = 1'b1;
                        jump_c      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = (bus.opcode == OP_SW);
                if (bus.mem_ready) begin
                    state_d = (bus.opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                wb_sel_c    = (bus.opcode == OP_LW) ? 2'b01 : 2'b00;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                    (state_d == S_FETCH);

    // A wait run only continues while we stay in FETCH/MEM, so any other cycle restarts it.
    assign wait_d = (in_mem_phase && !bus.mem_ready) ? wait_q + WAIT_W'(1) : '0;
    assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
    assign trap_d = trap_q || (state_d == S_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
        end
    end

    assign bus.mem_req     = mem_req_c   & ~rst;
    assign bus.mem_we      = mem_we_c    & ~rst;
    assign bus.iord        = iord_c      & ~rst;
    assign bus.ir_write    = ir_write_c  & ~rst;
    assign bus.pc_write    = pc_write_c  & ~rst;
    assign bus.branch      = branch_c    & ~rst;
    assign bus.jump        = jump_c      & ~rst;
    assign bus.reg_write   = reg_write_c & ~rst;
    assign bus.alu_src_a   = rst ? 2'b00 : src_a_c;
    assign bus.alu_src_b   = rst ? 2'b00 : src_b_c;
    assign bus.alu_op      = rst ? 2'b00 : alu_op_c;
    assign bus.wb_sel      = rst ? 2'b00 : wb_sel_c;
    assign bus.trap        = trap_q;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-scenario tasks compare each cycle against
// a trace built from instruction-level phase descriptions.
module tb_multicycle_control;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int W   = 20;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CW)) bus ();

    multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(CW), .WAIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         rdy_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    function automatic logic [W-1:0] ev(int st, int tr, int req, int we, int io, int irw,
                                        int pcw, int br, int jp, int rw, int wb,
                                        int a, int b, int op);
        return {3'(st), 1'(tr), 1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 1'(br),
                1'(jp), 1'(rw), 2'(wb), 2'(a), 2'(b), 2'(op)};
    endfunction

    function automatic logic [W-1:0] obs();
        return {bus.state, bus.trap, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write,
                bus.pc_write, bus.branch, bus.jump, bus.reg_write, bus.wb_sel,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op};
    endfunction

    task automatic push(logic [W-1:0] v, logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    task automatic add_fetch(int waits);
        repeat (waits) push(ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b0);
        push(ev(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0), 1'b1);
    endtask

    task automatic add_mem(int waits, int we);
        repeat (waits) push(ev(3, 0, 1, we, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        push(ev(3, 0, 1, we, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    endtask

    // Reference behaviour of one legal instruction, phase by phase.
    task automatic add_instr(logic [6:0] op, int fw, int mw);
        logic [W-1:0] wb_plain;
        wb_plain = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add_fetch(fw);
        push(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0), 1'($urandom_range(0, 1)));
        case (op)
            OP_R: begin
                push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 1'($urandom_range(0, 1)));
                push(wb_plain, 1'($urandom_range(0, 1)));
            end
            OP_I: begin
                push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3), 1'($urandom_range(0, 1)));
                push(wb_plain, 1'($urandom_range(0, 1)));
            end
            OP_LUI: begin
                push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'($urandom_range(0, 1)));
                push(wb_plain, 1'($urandom_range(0, 1)));
            end
            OP_LW: begin
                push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'($urandom_range(0, 1)));
                add_mem(mw, 0);
                push(ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'($urandom_range(0, 1)));
                add_mem(mw, 1);
            end
            OP_BEQ: push(ev(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1), 1'($urandom_range(0, 1)));
            default: push(ev(2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0), 1'($urandom_range(0, 1)));
        endcase
    endtask

    // Driver: applies mem_ready per cycle just after the edge, records outputs at negedge.
    task automatic run_trace();
        got_q.delete();
        foreach (rdy_q[i]) begin
            bus.mem_ready = rdy_q[i];
            @(negedge clk);
            got_q.push_back(obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd0 || bus.trap !== 1'b0 || bus.instr_count !== '0)
            $display("FAIL reset_state: state=%0d trap=%b cnt=%0d, want 0/0/0",
                     bus.state, bus.trap, bus.instr_count);
        else n_pass++;
        n_checks++;
        if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write} !== 4'b0000)
            $display("FAIL reset_strobes: req/irw/pcw/rw=%b, want 0000",
                     {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write});
        else n_pass++;
        do_reset();
    endtask

    task automatic test_rtype();
        do_reset();
        bus.opcode = OP_R;
        add_instr(OP_R, 0, 0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rtype cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        exp_cnt = 1;
        n_checks++;
        if (bus.instr_count !== CW'(exp_cnt)) $display("FAIL rtype_cnt: got %0d want %0d", bus.instr_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_lw_wait();
        do_reset();
        bus.opcode = OP_LW;
        add_instr(OP_LW, 0, 3);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL lw_wait cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.instr_count !== CW'(1) || bus.state !== 3'd0)
            $display("FAIL lw_done: cnt=%0d state=%0d want 1/0", bus.instr_count, bus.state);
        else n_pass++;
    endtask

    task automatic test_beq_jal();
        logic [6:0] ops[2];
        ops[0] = OP_BEQ;
        ops[1] = OP_JAL;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            rdy_q.delete();
            bus.opcode = ops[k];
            add_instr(ops[k], 0, 0);
            run_trace();
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) $display("FAIL beq_jal op%0d cyc%0d: got %h want %h", k, i, got_q[i], exp_q[i]);
                else n_pass++;
            end
            exp_cnt++;
            n_checks++;
            if (bus.instr_count !== CW'(exp_cnt) || bus.state !== 3'd0)
                $display("FAIL beq_jal_retire op%0d: cnt=%0d state=%0d want %0d/0", k, bus.instr_count, bus.state, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[7];
        logic [6:0] op;
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_LUI};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            exp_q.delete();
            rdy_q.delete();
            op = ops[$urandom_range(0, 6)];
            bus.opcode = op;
            add_instr(op, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
            run_trace();
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) $display("FAIL random n%0d op=%b cyc%0d: got %h want %h", n, op, i, got_q[i], exp_q[i]);
                else n_pass++;
            end
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            n_checks++;
            if (bus.instr_count !== CW'(exp_cnt)) $display("FAIL random_cnt n%0d: got %0d want %0d", n, bus.instr_count, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.opcode = OP_I;
        add_instr(OP_I, 0, 0);
        run_trace();
        exp_q.delete();
        rdy_q.delete();
        bus.opcode = OP_BAD;
        add_fetch(int'($urandom_range(0, 2)));
        push(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0), 1'b1);
        repeat (20) push(ev(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL illegal cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.instr_count !== CW'(1)) $display("FAIL illegal_cnt: got %0d want 1", bus.instr_count);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd0 || bus.trap !== 1'b0 || bus.instr_count !== '0)
            $display("FAIL illegal_recover: state=%0d trap=%b cnt=%0d want 0/0/0", bus.state, bus.trap, bus.instr_count);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.opcode = OP_R;
        repeat (TMO) push(ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b0);
        repeat (3) push(ev(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL timeout cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        do_reset();
        bus.opcode = OP_R;
        add_fetch(TMO - 1);
        push(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0), 1'b0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL timeout_edge cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sw_reset();
        do_reset();
        bus.opcode = OP_R;
        add_instr(OP_R, 0, 0);
        run_trace();
        n_checks++;
        if (bus.instr_count !== CW'(1)) $display("FAIL sw_reset_pre: cnt=%0d want 1", bus.instr_count);
        else n_pass++;
        exp_q.delete();
        rdy_q.delete();
        bus.opcode = OP_SW;
        add_fetch(0);
        push(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0), 1'b0);
        push(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), 1'b0);
        push(ev(3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL sw_reset cyc%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0)
            $display("FAIL sw_reset_strobe: req=%b we=%b want 0/0", bus.mem_req, bus.mem_we);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0 || bus.instr_count !== '0)
            $display("FAIL sw_reset_abort: state=%0d cnt=%0d want 0/0", bus.state, bus.instr_count);
        else n_pass++;
    endtask

    initial begin
        bus.opcode = OP_R;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq_jal();
        test_illegal();
        test_timeout();
        test_sw_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
